// File: rtl/pc_stack_pkg.sv
// Shared constants, command encoding and priority arbitration for the
// merged program counter / return stack unit.
package pc_stack_pkg;

  localparam int OVF_WRAP = 0;
  localparam int OVF_SAT  = 1;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_PAGE,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } pc_cmd_t;

  // Hold freezes everything, so it decodes to no command at all.
  function automatic pc_cmd_t prioEncode(input logic holdEn,
                                         input logic retEn,
                                         input logic callEn,
                                         input logic loadEn,
                                         input logic pageLoadEn,
                                         input logic incEn);
    pc_cmd_t cmd;
    if (holdEn)          cmd = CMD_NONE;
    else if (retEn)      cmd = CMD_RET;
    else if (callEn)     cmd = CMD_CALL;
    else if (loadEn)     cmd = CMD_LOAD;
    else if (pageLoadEn) cmd = CMD_PAGE;
    else if (incEn)      cmd = CMD_INC;
    else                 cmd = CMD_NONE;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_stack_array.sv
// Circular return-address register file with push/pop pointer and depth count.
// Overflow policy is decided by the caller; a push while full overwrites the oldest entry.
module pc_stack_array #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 3,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               pushEn,
  input  logic               popEn,
  input  logic [ADDR_W-1:0]  pushData,
  output logic [ADDR_W-1:0]  topData,
  output logic [DEPTH_W-1:0] depthOut,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  entryQ [DEPTH];
  logic [ADDR_W-1:0]  entryD [DEPTH];
  logic [PTR_W-1:0]   ptrQ, ptrD, ptrInc, ptrDec;
  logic [DEPTH_W-1:0] depthQ, depthD;

  assign ptrInc = (ptrQ == PTR_W'(DEPTH - 1)) ? '0 : ptrQ + PTR_W'(1);
  assign ptrDec = (ptrQ == '0) ? PTR_W'(DEPTH - 1) : ptrQ - PTR_W'(1);

  assign topData  = entryQ[ptrDec];
  assign depthOut = depthQ;
  assign full     = (depthQ == DEPTH_W'(DEPTH));
  assign empty    = (depthQ == '0);

  // Pop on empty still moves the pointer; depth simply refuses to go negative.
  always_comb begin
    entryD = entryQ;
    ptrD   = ptrQ;
    depthD = depthQ;
    if (pushEn) begin
      entryD[ptrQ] = pushData;
      ptrD         = ptrInc;
      if (!full) depthD = depthQ + DEPTH_W'(1);
    end else if (popEn) begin
      ptrD = ptrDec;
      if (!empty) depthD = depthQ - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) entryQ[i] <= '0;
      ptrQ   <= '0;
      depthQ <= '0;
    end else begin
      entryQ <= entryD;
      ptrQ   <= ptrD;
      depthQ <= depthD;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter merged with the subroutine return stack, one command per clock.
// Define PC_TRACE_EN to add the branchValid/branchFrom/branchTo trace outputs.
module pc_call_stack
  import pc_stack_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int PAGE_W   = 8,
  parameter int DEPTH    = 3,
  parameter int OVF_MODE = 0,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               holdEn,
  input  logic               incEn,
  input  logic               pageLoadEn,
  input  logic [PAGE_W-1:0]  pageAddr,
  input  logic               loadEn,
  input  logic [ADDR_W-1:0]  loadAddr,
  input  logic               callEn,
  input  logic [ADDR_W-1:0]  callAddr,
  input  logic               retEn,
  input  logic               clrFlags,
  output logic [ADDR_W-1:0]  pcAddr,
  output logic [ADDR_W-1:0]  topAddr,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow
`ifdef PC_TRACE_EN
  ,
  output logic               branchValid,
  output logic [ADDR_W-1:0]  branchFrom,
  output logic [ADDR_W-1:0]  branchTo
`endif
);

  pc_cmd_t           cmd;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic              ovfQ, ovfD, unfQ, unfD;
  logic              pushEn, popEn, full, empty;
  logic [ADDR_W-1:0] topData;

  assign cmd = prioEncode(holdEn, retEn, callEn, loadEn, pageLoadEn, incEn);

  // Saturate mode turns push-on-full and pop-on-empty into no-ops on the stack.
  assign pushEn = (cmd == CMD_CALL) && ((OVF_MODE == OVF_WRAP) || !full);
  assign popEn  = (cmd == CMD_RET)  && ((OVF_MODE == OVF_WRAP) || !empty);

  pc_stack_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) uStack (
    .clk      (clk),
    .rstN     (rstN),
    .pushEn   (pushEn),
    .popEn    (popEn),
    .pushData (pcQ),
    .topData  (topData),
    .depthOut (depth),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    pcD = pcQ;
    unique case (cmd)
      CMD_INC:  pcD = pcQ + ADDR_W'(1);
      CMD_PAGE: pcD = {pcQ[ADDR_W-1:PAGE_W], pageAddr};
      CMD_LOAD: pcD = loadAddr;
      CMD_CALL: pcD = callAddr;
      CMD_RET:  pcD = popEn ? topData : pcQ;
      default:  pcD = pcQ;
    endcase
  end

  // A flag-setting event in the same cycle as clrFlags leaves the flag set.
  always_comb begin
    ovfD = ovfQ;
    unfD = unfQ;
    if (!holdEn) begin
      if (clrFlags) begin
        ovfD = 1'b0;
        unfD = 1'b0;
      end
      if (cmd == CMD_CALL && full)  ovfD = 1'b1;
      if (cmd == CMD_RET  && empty) unfD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pcQ  <= '0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      pcQ  <= pcD;
      ovfQ <= ovfD;
      unfQ <= unfD;
    end
  end

  assign pcAddr    = pcQ;
  assign topAddr   = topData;
  assign overflow  = ovfQ;
  assign underflow = unfQ;

`ifdef PC_TRACE_EN
  logic              branchValidQ, branchValidD;
  logic [ADDR_W-1:0] branchFromQ, branchToQ;

  assign branchValidD = (cmd == CMD_CALL) || (cmd == CMD_RET) ||
                        (cmd == CMD_LOAD) || (cmd == CMD_PAGE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      branchValidQ <= 1'b0;
      branchFromQ  <= '0;
      branchToQ    <= '0;
    end else begin
      branchValidQ <= branchValidD;
      if (branchValidD) begin
        branchFromQ <= pcQ;
        branchToQ   <= pcD;
      end
    end
  end

  assign branchValid = branchValidQ;
  assign branchFrom  = branchFromQ;
  assign branchTo    = branchToQ;
`endif

endmodule
